tile_update_writer: RTL and testbench

TILE_UPDATE_WRITER -- requirements
Module: tile_update_writer

---
 rtl/tile_update_writer.sv | 167 ++++++++++++++++
 tb/tb_tile_update_writer.sv | 546 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_update_writer.sv
// tile_update_writer: mirrors the falling piece into the tile RAM.
// Clears the board after reset, then erases/redraws the piece on change.

module tile_update_writer #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20
) (
  input  logic            frame_clk,
  input  logic            Reset,
  input  logic [3:0][6:0] blockXPos,
  input  logic [3:0][6:0] blockYPos,
  input  logic [3:0]      blockColor,
  input  logic            tile_ack,
  output logic            tile_we,
  output logic [7:0]      tile_addr,
  output logic [3:0]      tile_wdata,
  output logic            busy,
  output logic            update_done
);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    ERASE,
    DRAW
  } state_t;

  localparam logic [7:0] LAST_ADDR = 8'(BOARD_W * BOARD_H - 1);
  localparam logic [7:0] W8 = 8'(BOARD_W);
  localparam logic [6:0] W7 = 7'(BOARD_W);
  localparam logic [6:0] H7 = 7'(BOARD_H);

  state_t          state, state_n;
  logic [1:0]      slot, slot_n;
  logic [7:0]      clr_addr, clr_addr_n;
  logic [3:0][6:0] drawn_x, drawn_y;
  logic [3:0][6:0] snap_x, snap_y;
  logic [3:0]      drawn_c, snap_c;
  logic            latch, commit, done_n;
  logic [6:0]      cur_x, cur_y;
  logic            in_bounds, changed;
  logic [7:0]      cell_addr;

  assign busy = (state != IDLE);

  assign changed = (blockXPos != drawn_x) ||
                   (blockYPos != drawn_y) ||
                   (blockColor != drawn_c);

  // Select the cell for the current slot: old piece when erasing.
  always_comb begin
    cur_x = snap_x[slot];
    cur_y = snap_y[slot];
    if (state == ERASE) begin
      cur_x = drawn_x[slot];
      cur_y = drawn_y[slot];
    end
    in_bounds = (cur_x < W7) && (cur_y < H7);
    cell_addr = {1'b0, cur_y} * W8 + {1'b0, cur_x};
  end

  // State, slot and clear-address registers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= CLEAR;
      slot        <= 2'd0;
      clr_addr    <= 8'd0;
      update_done <= 1'b0;
    end else begin
      state       <= state_n;
      slot        <= slot_n;
      clr_addr    <= clr_addr_n;
      update_done <= done_n;
    end
  end

  // Snapshot on a detected change; commit snapshot once drawn.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      drawn_x <= {4{7'h7F}};
      drawn_y <= {4{7'h7F}};
      drawn_c <= 4'd0;
      snap_x  <= '0;
      snap_y  <= '0;
      snap_c  <= 4'd0;
    end else begin
      if (latch) begin
        snap_x <= blockXPos;
        snap_y <= blockYPos;
        snap_c <= blockColor;
      end
      if (commit) begin
        drawn_x <= snap_x;
        drawn_y <= snap_y;
        drawn_c <= snap_c;
      end
    end
  end

  // Next state and write-port outputs; off-board cells burn one idle cycle.
  always_comb begin
    state_n    = state;
    slot_n     = slot;
    clr_addr_n = clr_addr;
    latch      = 1'b0;
    commit     = 1'b0;
    done_n     = 1'b0;
    tile_we    = 1'b0;
    tile_addr  = 8'd0;
    tile_wdata = 4'd0;
    unique case (state)
      CLEAR: begin
        tile_we   = 1'b1;
        tile_addr = clr_addr;
        if (tile_ack) begin
          if (clr_addr == LAST_ADDR) begin
            state_n = IDLE;
          end else begin
            clr_addr_n = clr_addr + 8'd1;
          end
        end
      end
      IDLE: begin
        if (changed) begin
          latch  = 1'b1;
          slot_n = 2'd0;
          if (blockColor == drawn_c) begin
            state_n = ERASE;
          end else begin
            state_n = DRAW;
          end
        end
      end
      ERASE: begin
        tile_we   = in_bounds;
        tile_addr = in_bounds ? cell_addr : 8'd0;
        if (!in_bounds || tile_ack) begin
          slot_n = slot + 2'd1;
          if (slot == 2'd3) begin
            state_n = DRAW;
            slot_n  = 2'd0;
          end
        end
      end
      DRAW: begin
        tile_we    = in_bounds;
        tile_addr  = in_bounds ? cell_addr : 8'd0;
        tile_wdata = in_bounds ? snap_c : 4'd0;
        if (!in_bounds || tile_ack) begin
          slot_n = slot + 2'd1;
          if (slot == 2'd3) begin
            state_n = IDLE;
            slot_n  = 2'd0;
            commit  = 1'b1;
            done_n  = 1'b1;
          end
        end
      end
    endcase
    if (Reset) begin
      tile_we    = 1'b0;
      tile_addr  = 8'd0;
      tile_wdata = 4'd0;
    end
  end

endmodule

// File: tb/tb_tile_update_writer.sv
// tb_tile_update_writer: randomized self-checking bench.
// A board-level model predicts the write stream and final tile contents.

module tb_tile_update_writer;

  localparam int W = 10;
  localparam int H = 20;
  localparam int N = W * H;

  logic            frame_clk = 1'b0;
  logic            Reset = 1'b0;
  logic [3:0][6:0] blockXPos;
  logic [3:0][6:0] blockYPos;
  logic [3:0]      blockColor;
  logic            tile_ack;
  logic            tile_we;
  logic [7:0]      tile_addr;
  logic [3:0]      tile_wdata;
  logic            busy;
  logic            update_done;

  tile_update_writer #(
    .BOARD_W(W),
    .BOARD_H(H)
  ) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .blockXPos  (blockXPos),
    .blockYPos  (blockYPos),
    .blockColor (blockColor),
    .tile_ack   (tile_ack),
    .tile_we    (tile_we),
    .tile_addr  (tile_addr),
    .tile_wdata (tile_wdata),
    .busy       (busy),
    .update_done(update_done)
  );

  always #5 frame_clk = ~frame_clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  logic [11:0] wr_q[$];
  bit          we_q[$];
  logic [3:0]  ram[0:255];

  // Tile RAM stand-in: a write pending at the falling edge with ack
  // completes on the next rising edge.
  always @(negedge frame_clk) begin
    if (!Reset && update_done) done_cnt <= done_cnt + 1;
    if (!Reset && tile_we && tile_ack) begin
      wr_q.push_back({tile_addr, tile_wdata});
      ram[tile_addr] <= tile_wdata;
    end
  end

  // Reference model: piece on board plus expected write stream.
  int          mx[4];
  int          my[4];
  int          mc;
  int          m_board[N];
  logic [11:0] exp_q[$];
  bit          exp_we[$];

  function automatic bit inb(int x, int y);
    return (x < W) && (y < H);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mx[i] = 127;
      my[i] = 127;
    end
    mc = 0;
    for (int i = 0; i < N; i++) m_board[i] = 0;
  endtask

  task automatic model_update(input int nx[4], input int ny[4], input int nc);
    exp_q.delete();
    exp_we.delete();
    if (nc == mc) begin
      for (int i = 0; i < 4; i++) begin
        exp_we.push_back(inb(mx[i], my[i]));
        if (inb(mx[i], my[i])) begin
          exp_q.push_back({8'(my[i] * W + mx[i]), 4'd0});
          m_board[my[i] * W + mx[i]] = 0;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp_we.push_back(inb(nx[i], ny[i]));
      if (inb(nx[i], ny[i])) begin
        exp_q.push_back({8'(ny[i] * W + nx[i]), 4'(nc)});
        m_board[ny[i] * W + nx[i]] = nc;
      end
    end
    for (int i = 0; i < 4; i++) begin
      mx[i] = nx[i];
      my[i] = ny[i];
    end
    mc = nc;
  endtask

  function automatic int writes_bad();
    int bad = 0;
    if (wr_q.size() != exp_q.size()) bad++;
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      if (wr_q[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  function automatic int trace_bad();
    int bad = 0;
    if (we_q.size() != exp_we.size()) bad++;
    for (int i = 0; i < we_q.size() && i < exp_we.size(); i++)
      if (we_q[i] !== exp_we[i]) bad++;
    return bad;
  endfunction

  task automatic drive_piece(input int nx[4], input int ny[4], input int nc);
    @(posedge frame_clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      blockXPos[i] = 7'(nx[i]);
      blockYPos[i] = 7'(ny[i]);
    end
    blockColor = 4'(nc);
    tile_ack = 1'b1;
  endtask

  task automatic wait_done(input bit rand_ack, output int cyc, output bit tmo);
    cyc = 0;
    tmo = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge frame_clk);
      if (busy) begin
        cyc++;
        we_q.push_back(tile_we);
      end
      if (update_done) begin
        tmo = 1'b0;
        break;
      end
      @(posedge frame_clk);
      #1;
      if (rand_ack) tile_ack = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    #1 Reset = 1'b1;
    #2;
    n_checks++;
    if (tile_we !== 1'b0) $display("FAIL reset_we: got %b want 0", tile_we);
    if (tile_we !== 1'b0) n_fail++;
    n_checks++;
    if (tile_addr !== 8'd0) begin
      $display("FAIL reset_addr: got %0d want 0", tile_addr);
      n_fail++;
    end
    n_checks++;
    if (tile_wdata !== 4'd0) begin
      $display("FAIL reset_wdata: got %0d want 0", tile_wdata);
      n_fail++;
    end
    n_checks++;
    if (busy !== 1'b1) begin
      $display("FAIL reset_busy: got %b want 1", busy);
      n_fail++;
    end
    n_checks++;
    if (update_done !== 1'b0) begin
      $display("FAIL reset_done: got %b want 0", update_done);
      n_fail++;
    end
    repeat (2) @(posedge frame_clk);
  endtask

  task automatic test_clear();
    int cyc, d0, bad;
    bit tmo;
    wr_q.delete();
    @(posedge frame_clk);
    #1 Reset = 1'b0;
    d0 = done_cnt;
    cyc = 0;
    tmo = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge frame_clk);
      if (!busy) begin
        tmo = 1'b0;
        break;
      end
      cyc++;
    end
    #2;
    n_checks++;
    if (tmo) begin
      $display("FAIL clear_idle: busy still %b after 1000 cycles", busy);
      n_fail++;
    end
    n_checks++;
    if (cyc != N) begin
      $display("FAIL clear_cycles: got %0d want %0d", cyc, N);
      n_fail++;
    end
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++)
      if (wr_q[i] !== {8'(i), 4'd0}) bad++;
    n_checks++;
    if (wr_q.size() != N || bad != 0) begin
      $display("FAIL clear_writes: got %0d writes (%0d wrong) want %0d zero writes",
               wr_q.size(), bad, N);
      n_fail++;
    end
    n_checks++;
    if (done_cnt != d0) begin
      $display("FAIL clear_no_done: got %0d pulses want 0", done_cnt - d0);
      n_fail++;
    end
  endtask

  task automatic test_first_draw();
    int x[4], y[4];
    int cyc;
    bit tmo;
    x = '{4, 5, 5, 6};
    y = '{0, 0, 1, 1};
    model_update(x, y, 1);
    wr_q.delete();
    we_q.delete();
    drive_piece(x, y, 1);
    wait_done(1'b0, cyc, tmo);
    n_checks++;
    if (tmo) begin
      $display("FAIL first_done: no update_done within bound");
      n_fail++;
    end
    n_checks++;
    if (cyc != 4) begin
      $display("FAIL first_cycles: got %0d want 4", cyc);
      n_fail++;
    end
    n_checks++;
    if (writes_bad() != 0) begin
      $display("FAIL first_writes: got %0d writes want %0d (addr 4,5,15,16 data 1)",
               wr_q.size(), exp_q.size());
      n_fail++;
    end
  endtask

  task automatic test_move();
    int x[4], y[4];
    int cyc;
    bit tmo;
    x = '{4, 5, 5, 6};
    y = '{1, 1, 2, 2};
    model_update(x, y, 1);
    wr_q.delete();
    we_q.delete();
    drive_piece(x, y, 1);
    wait_done(1'b0, cyc, tmo);
    n_checks++;
    if (tmo || cyc != 8) begin
      $display("FAIL move_cycles: got %0d (timeout %b) want 8", cyc, tmo);
      n_fail++;
    end
    n_checks++;
    if (writes_bad() != 0) begin
      $display("FAIL move_writes: got %0d writes want %0d", wr_q.size(), exp_q.size());
      n_fail++;
    end
  endtask

  task automatic test_color_change();
    int x[4], y[4];
    int cyc;
    bit tmo;
    x = '{0, 1, 1, 2};
    y = '{3, 3, 4, 4};
    model_update(x, y, 2);
    wr_q.delete();
    we_q.delete();
    drive_piece(x, y, 2);
    wait_done(1'b0, cyc, tmo);
    n_checks++;
    if (tmo || cyc != 4) begin
      $display("FAIL color_cycles: got %0d (timeout %b) want 4", cyc, tmo);
      n_fail++;
    end
    n_checks++;
    if (writes_bad() != 0) begin
      $display("FAIL color_writes: got %0d writes want %0d draws of 2",
               wr_q.size(), exp_q.size());
      n_fail++;
    end
  endtask

  task automatic test_ack_stall();
    int x[4], y[4];
    int cyc;
    bit tmo;
    x = '{0, 1, 2, 3};
    y = '{10, 10, 10, 10};
    model_update(x, y, 3);
    wr_q.delete();
    we_q.delete();
    drive_piece(x, y, 3);
    @(posedge frame_clk);
    #1;
    @(posedge frame_clk);
    #1 tile_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge frame_clk);
      n_checks++;
      if (tile_we !== 1'b1 || {tile_addr, tile_wdata} !== exp_q[1]) begin
        $display("FAIL stall_hold: we %b addr %0d data %0d want we 1 addr %0d data %0d",
                 tile_we, tile_addr, tile_wdata, exp_q[1][11:4], exp_q[1][3:0]);
        n_fail++;
      end
      @(posedge frame_clk);
      #1;
    end
    tile_ack = 1'b1;
    wait_done(1'b0, cyc, tmo);
    n_checks++;
    if (tmo || writes_bad() != 0) begin
      $display("FAIL stall_writes: got %0d writes (timeout %b) want %0d",
               wr_q.size(), tmo, exp_q.size());
      n_fail++;
    end
  endtask

  task automatic test_skip();
    int x[4], y[4];
    int cyc;
    bit tmo;
    x = '{8, 9, 10, 9};
    y = '{5, 5, 5, 6};
    model_update(x, y, 3);
    wr_q.delete();
    we_q.delete();
    drive_piece(x, y, 3);
    wait_done(1'b0, cyc, tmo);
    n_checks++;
    if (tmo || cyc != 8) begin
      $display("FAIL skip_cycles: got %0d (timeout %b) want 8", cyc, tmo);
      n_fail++;
    end
    n_checks++;
    if (we_q.size() != 8 || we_q[6] !== 1'b0 || trace_bad() != 0) begin
      $display("FAIL skip_we_trace: %0d mismatching cycles of %0d", trace_bad(), we_q.size());
      n_fail++;
    end
    n_checks++;
    if (writes_bad() != 0) begin
      $display("FAIL skip_writes: got %0d writes want %0d", wr_q.size(), exp_q.size());
      n_fail++;
    end
  endtask

  task automatic test_busy_ignore();
    int xa[4], ya[4], yb[4];
    int cyc;
    bit tmo;
    xa = '{3, 4, 5, 6};
    ya = '{2, 2, 2, 2};
    yb = '{3, 3, 3, 3};
    model_update(xa, ya, 3);
    wr_q.delete();
    we_q.delete();
    drive_piece(xa, ya, 3);
    @(posedge frame_clk);
    #1;
    @(posedge frame_clk);
    #1;
    for (int i = 0; i < 4; i++) blockYPos[i] = 7'(yb[i]);
    wait_done(1'b0, cyc, tmo);
    n_checks++;
    if (tmo || writes_bad() != 0) begin
      $display("FAIL busy_first: got %0d writes (timeout %b) want %0d",
               wr_q.size(), tmo, exp_q.size());
      n_fail++;
    end
    model_update(xa, yb, 3);
    wr_q.delete();
    we_q.delete();
    wait_done(1'b0, cyc, tmo);
    n_checks++;
    if (tmo || cyc != 8 || writes_bad() != 0) begin
      $display("FAIL busy_followup: got %0d writes in %0d cycles (timeout %b) want %0d in 8",
               wr_q.size(), cyc, tmo, exp_q.size());
      n_fail++;
    end
  endtask

  task automatic test_random();
    int x[4], y[4];
    int nc, cyc;
    bit tmo, same, rack;
    for (int k = 0; k < 24; k++) begin
      rack = 1'(k % 2);
      for (int i = 0; i < 4; i++) begin
        x[i] = $urandom_range(0, 11);
        y[i] = $urandom_range(0, 21);
      end
      nc = ($urandom_range(0, 1) == 1) ? mc : int'($urandom_range(1, 15));
      same = (nc == mc);
      for (int i = 0; i < 4; i++)
        if (x[i] != mx[i] || y[i] != my[i]) same = 1'b0;
      if (same) nc = (mc % 15) + 1;
      model_update(x, y, nc);
      wr_q.delete();
      we_q.delete();
      drive_piece(x, y, nc);
      wait_done(rack, cyc, tmo);
      n_checks++;
      if (tmo || writes_bad() != 0) begin
        $display("FAIL rand_writes[%0d]: got %0d writes (timeout %b) want %0d",
                 k, wr_q.size(), tmo, exp_q.size());
        n_fail++;
      end
      if (!rack) begin
        n_checks++;
        if (cyc != exp_we.size() || trace_bad() != 0) begin
          $display("FAIL rand_timing[%0d]: got %0d cycles want %0d, %0d trace errors",
                   k, cyc, exp_we.size(), trace_bad());
          n_fail++;
        end
      end
    end
    tile_ack = 1'b1;
  endtask

  task automatic test_board();
    int bad;
    bad = 0;
    #2;
    for (int i = 0; i < N; i++)
      if (ram[i] !== 4'(m_board[i])) bad++;
    n_checks++;
    if (bad != 0) begin
      $display("FAIL board_contents: got %0d wrong cells want 0", bad);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_erase();
    int x[4], y[4], y1[4];
    int cyc, bad;
    bit tmo;
    x = '{0, 1, 2, 3};
    y = '{0, 0, 0, 0};
    y1 = '{1, 1, 1, 1};
    model_update(x, y, (mc % 15) + 1);
    wr_q.delete();
    we_q.delete();
    drive_piece(x, y, mc);
    wait_done(1'b0, cyc, tmo);
    n_checks++;
    if (tmo) begin
      $display("FAIL rst_setup: no update_done within bound");
      n_fail++;
    end
    wr_q.delete();
    drive_piece(x, y1, mc);
    @(posedge frame_clk);
    #1;
    @(posedge frame_clk);
    #1;
    n_checks++;
    if (tile_we !== 1'b1) begin
      $display("FAIL rst_erase_active: got we %b want 1", tile_we);
      n_fail++;
    end
    #2 Reset = 1'b1;
    #1;
    n_checks++;
    if (tile_we !== 1'b0 || tile_addr !== 8'd0 || busy !== 1'b1) begin
      $display("FAIL rst_async: we %b addr %0d busy %b want 0 0 1", tile_we, tile_addr, busy);
      n_fail++;
    end
    for (int i = 0; i < 4; i++) begin
      blockXPos[i] = 7'h7F;
      blockYPos[i] = 7'h7F;
    end
    blockColor = 4'd0;
    repeat (2) @(posedge frame_clk);
    #1;
    n_checks++;
    if (wr_q.size() != 1 || tile_we !== 1'b0) begin
      $display("FAIL rst_no_write: got %0d writes we %b want 1 write we 0", wr_q.size(), tile_we);
      n_fail++;
    end
    model_reset();
    wr_q.delete();
    @(posedge frame_clk);
    #1 Reset = 1'b0;
    cyc = 0;
    tmo = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge frame_clk);
      if (!busy) begin
        tmo = 1'b0;
        break;
      end
      cyc++;
    end
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++)
      if (wr_q[i] !== {8'(i), 4'd0}) bad++;
    n_checks++;
    if (tmo || cyc != N || wr_q.size() != N || bad != 0) begin
      $display("FAIL rst_reclear: %0d writes (%0d wrong) in %0d cycles timeout %b want %0d from addr 0",
               wr_q.size(), bad, cyc, tmo, N);
      n_fail++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      blockXPos[i] = 7'h7F;
      blockYPos[i] = 7'h7F;
    end
    blockColor = 4'd0;
    tile_ack = 1'b1;
    model_reset();
    test_reset();
    test_clear();
    test_first_draw();
    test_move();
    test_color_change();
    test_ack_stall();
    test_skip();
    test_busy_ignore();
    test_random();
    test_board();
    test_reset_mid_erase();
    test_board();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
